// File: rtl/exe_div_ctrl_if.sv
// Handshake and result bus between the execute stage and the divider.
// The master (execute stage) issues instructions and operands.
// The slave (divider) returns busy, the write strobe and the result.
interface exe_div_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  flush_i;
    logic [31:0]           inst_i;
    logic [DATA_WIDTH-1:0] op1_i;
    logic [DATA_WIDTH-1:0] op2_i;
    logic [4:0]            reg_waddr_i;

    logic                  busy_o;
    logic                  reg_we_o;
    logic [4:0]            reg_waddr_o;
    logic [DATA_WIDTH-1:0] reg_wdata_o;

    modport master (
        output start_i, flush_i, inst_i, op1_i, op2_i, reg_waddr_i,
        input  busy_o, reg_we_o, reg_waddr_o, reg_wdata_o
    );

    modport slave (
        input  start_i, flush_i, inst_i, op1_i, op2_i, reg_waddr_i,
        output busy_o, reg_we_o, reg_waddr_o, reg_wdata_o
    );
endinterface

// File: rtl/exe_div_ctrl.sv
// RV32M divide unit: DIV/DIVU/REM/REMU using a restoring radix-2 divider.
// A normal operation takes 32 CALC cycles plus one DONE cycle.
// Divide-by-zero and signed overflow skip CALC and go straight to DONE.
module exe_div_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    exe_div_ctrl_if.slave bus
);
    localparam logic [6:0]            OPCODE_OP     = 7'b0110011;
    localparam logic [6:0]            FUNCT7_MULDIV = 7'b0000001;
    localparam logic [DATA_WIDTH-1:0] INT_MIN       = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Latched operation state.
    logic [DATA_WIDTH-1:0] quo_q;     // dividend shifts out, quotient shifts in
    logic [DATA_WIDTH-1:0] rem_q;     // partial remainder
    logic [DATA_WIDTH-1:0] dsr_q;     // divisor magnitude
    logic                  rem_op_q;  // 1: REM/REMU result, 0: DIV/DIVU result
    logic                  quo_neg_q;
    logic                  rem_neg_q;
    logic [4:0]            rd_q;
    logic [4:0]            cnt_q;

    // Instruction decode.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_div;
    logic       accept;
    logic       op_signed;
    logic       div_zero;
    logic       overflow;
    logic       special;
    logic       op1_neg;
    logic       op2_neg;
    logic [DATA_WIDTH-1:0] op1_mag;
    logic [DATA_WIDTH-1:0] op2_mag;

    // Iteration step.
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] result;

    // Register-address fields are not needed by the divider itself.
    logic unused_inst_bits;

    assign opcode    = bus.inst_i[6:0];
    assign funct3    = bus.inst_i[14:12];
    assign funct7    = bus.inst_i[31:25];
    assign is_div    = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
    assign accept    = bus.start_i && (state_q == IDLE) && !bus.flush_i && is_div;
    assign op_signed = ~funct3[0];
    assign div_zero  = (bus.op2_i == '0);
    assign overflow  = op_signed && (bus.op1_i == INT_MIN) && (bus.op2_i == '1);
    assign special   = div_zero || overflow;
    assign op1_neg   = op_signed & bus.op1_i[DATA_WIDTH-1];
    assign op2_neg   = op_signed & bus.op2_i[DATA_WIDTH-1];
    assign op1_mag   = op1_neg ? -bus.op1_i : bus.op1_i;
    assign op2_mag   = op2_neg ? -bus.op2_i : bus.op2_i;

    assign unused_inst_bits = ^{bus.inst_i[24:15], bus.inst_i[11:7], diff[DATA_WIDTH]};

    // Restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        trial = {rem_q, quo_q[DATA_WIDTH-1]};
        diff  = trial - {1'b0, dsr_q};
        q_bit = (trial >= {1'b0, dsr_q});
    end

    // Final sign correction; negating zero leaves zero, so a zero quotient stays positive.
    always_comb begin
        result = '0;
        if (rem_op_q) begin
            result = rem_neg_q ? -rem_q : rem_q;
        end else begin
            result = quo_neg_q ? -quo_q : quo_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and bus outputs.
    always_comb begin
        state_d         = state_q;
        bus.busy_o      = 1'b0;
        bus.reg_we_o    = 1'b0;
        bus.reg_waddr_o = '0;
        bus.reg_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                bus.busy_o = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy_o      = 1'b1;
                bus.reg_we_o    = ~bus.flush_i;
                bus.reg_waddr_o = rd_q;
                bus.reg_wdata_o = result;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on acceptance and one quotient bit per CALC cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            rem_op_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            rem_op_q <= funct3[1];
            rd_q     <= bus.reg_waddr_i;
            cnt_q    <= '0;
            dsr_q    <= op2_mag;
            if (special) begin
                // Special results are loaded pre-signed; no correction applied.
                quo_q     <= div_zero ? '1 : INT_MIN;
                rem_q     <= div_zero ? bus.op1_i : '0;
                quo_neg_q <= 1'b0;
                rem_neg_q <= 1'b0;
            end else begin
                quo_q     <= op1_mag;
                rem_q     <= '0;
                quo_neg_q <= op1_neg ^ op2_neg;
                rem_neg_q <= op1_neg;
            end
        end else if (state_q == CALC) begin
            quo_q <= {quo_q[DATA_WIDTH-2:0], q_bit};
            rem_q <= q_bit ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            cnt_q <= cnt_q + 5'd1;
        end
    end
endmodule

// File: doc/exe_div_ctrl.md
EXE_DIV_CTRL -- requirements
Module: exe_div_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1, request to begin the instruction on inst_i.
REQ-005 SHALL have port flush_i, input, 1, abort any in-flight operation.
REQ-006 SHALL have port inst_i, input, 32, instruction word.
REQ-007 SHALL have ports op1_i and op2_i, input, 32 each, dividend (rs1) and divisor (rs2).
REQ-008 SHALL have port reg_waddr_i, input, 5, destination register.
REQ-009 SHALL have port busy_o, output, 1, high while state is not IDLE; pipeline stall request.
REQ-010 SHALL have port reg_we_o, output, 1, one-cycle result-write strobe.
REQ-011 SHALL have port reg_waddr_o, output, 5, latched destination register.
REQ-012 SHALL have port reg_wdata_o, output, 32, result value.

Function
REQ-013 SHALL accept an instruction only when start_i=1, state=IDLE, flush_i=0, opcode=0110011, funct7=0000001, funct3[2]=1.
REQ-014 SHALL decode funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 SHALL ignore start_i in all other cases, including while busy, with no state change.
REQ-016 SHALL latch op1_i, op2_i, reg_waddr_i and the operation on acceptance; later input changes SHALL have no effect.
REQ-017 SHALL implement FSM states IDLE, CALC and DONE.
REQ-018 SHALL transition IDLE->CALC on a normal acceptance.
REQ-019 SHALL transition IDLE->DONE on a special-case acceptance (REQ-023, REQ-024).
REQ-020 SHALL transition CALC->DONE after exactly 32 CALC cycles, counted by a 5-bit counter that wraps from 31 to 0.
REQ-021 SHALL transition DONE->IDLE unconditionally.
REQ-022 SHALL compute the normal case with a restoring radix-2 divider, one quotient bit per CALC cycle, on magnitudes; for DIV/REM, quotient negative iff operand signs differ and quotient nonzero, remainder takes the dividend's sign.
REQ-023 SHALL handle divisor = 0 as follows: quotient = 0xFFFFFFFF and remainder = op1, for signed and unsigned operations.
REQ-024 SHALL handle signed overflow (DIV/REM, op1 = 0x80000000, op2 = 0xFFFFFFFF) as follows: quotient = 0x80000000 and remainder = 0.
REQ-025 SHALL set latency relative to acceptance in cycle N: reg_we_o=1 in cycle N+33 for the normal case and N+1 for special cases.
REQ-026 SHALL hold busy_o=1 from N+1 through the DONE cycle.
REQ-027 SHALL drive reg_we_o = (state==DONE) & ~flush_i.
REQ-028 SHALL drive reg_wdata_o and reg_waddr_o with the result and latched rd while in DONE, and zero otherwise.
REQ-029 SHALL, when flush_i=1 in CALC or DONE, return the FSM to IDLE next cycle with no write; flush in IDLE SHALL block acceptance.
REQ-030 SHALL accept a new start in the cycle immediately after DONE (back-to-back).

Reset
REQ-031 SHALL, on rst_n_i=0 at any time including mid-operation, immediately force state=IDLE, counter=0 and clear all latched data.
REQ-032 SHALL force busy_o=0, reg_we_o=0, reg_wdata_o=0 and reg_waddr_o=0 during reset.
REQ-033 SHALL produce no write for an operation interrupted by reset.
REQ-034 SHALL accept a start in the first rising edge after reset deasserts.

Verification
REQ-035 SHALL verify DIVU 100/7 with rd=5, accepted at N: busy_o high for N+1..N+33; reg_we_o=1 only at N+33 with wdata=14 and waddr=5; REMU same operands gives 2.
REQ-036 SHALL verify DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, and REM same operands -> 0xFFFFFFFF, each at N+33.
REQ-037 SHALL verify DIV 5/0 -> 0xFFFFFFFF at N+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0.
REQ-038 SHALL verify DIVU 100/7 with flush_i pulsed at N+10: no reg_we_o; busy_o=0 at N+11; start at N+11 accepted.
REQ-039 SHALL verify rst_n_i low at N+20 of an operation: outputs zero immediately; no write afterward; a start after release completes normally.
REQ-040 SHALL verify that start_i with funct7=0000000 (ADD), and start_i while busy, cause no state change and no write.
